// File: rtl/writeback_stage_pkg.sv
// Shared widths and encodings for the MEM/WB stage of the R2000 core.
// Holds the result-source and load-size enums used by the stage and its load aligner.
package writeback_stage_pkg;
    localparam int WIDTH          = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD,
        WB_LINK,
        WB_HI,
        WB_LO
    } wb_src_t;

    typedef enum logic [1:0] {
        LS_BYTE,
        LS_HALF,
        LS_WORD
    } load_size_t;
endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Little-endian lane selection and zero/sign extension for sub-word loads.
// Illegal half/word alignments are flagged and produce zero data.
module load_aligner
    import writeback_stage_pkg::*;
#(
    parameter int WIDTH = writeback_stage_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] read_data,
    input  logic [1:0]       addr_lo,
    input  load_size_t       load_size,
    input  logic             load_signed,
    output logic [WIDTH-1:0] data,
    output logic             misaligned
);
    logic [7:0]  byte_lanes [4];
    logic [15:0] half_lanes [2];
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lanes[gi] = read_data[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lanes[gi] = read_data[16*gi +: 16];
        end
    endgenerate

    assign byte_lane = byte_lanes[addr_lo];
    assign half_lane = half_lanes[addr_lo[1]];

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (load_size)
            LS_BYTE: data = {{(WIDTH-8){load_signed & byte_lane[7]}}, byte_lane};
            LS_HALF: begin
                if (addr_lo[0]) misaligned = 1'b1;
                else            data = {{(WIDTH-16){load_signed & half_lane[15]}}, half_lane};
            end
            LS_WORD: begin
                if (addr_lo != 2'b00) misaligned = 1'b1;
                else                  data = read_data;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB pipeline stage: captures MEM results, selects the write-back value,
// gates the register-file write and counts retired instructions.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int WIDTH          = writeback_stage_pkg::WIDTH,
    parameter int REG_ADDR_WIDTH = writeback_stage_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32,
    parameter int LINK_OFFSET    = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_me,
    input  logic [WIDTH-1:0]          pc_me,
    input  logic                      rd_me,
    input  logic [REG_ADDR_WIDTH-1:0] rd_address_me,
    input  wb_src_t                   wb_src_me,
    input  load_size_t                load_size_me,
    input  logic                      load_signed_me,
    input  logic [1:0]                addr_lo_me,
    input  logic [WIDTH-1:0]          read_data_me,
    input  logic [WIDTH-1:0]          alu_result_me,
    input  logic [WIDTH-1:0]          hi_me,
    input  logic [WIDTH-1:0]          lo_me,
    output logic                      valid_wb,
    output logic [WIDTH-1:0]          pc_wb,
    output logic                      rd_wb,
    output logic [REG_ADDR_WIDTH-1:0] rd_address_wb,
    output logic [WIDTH-1:0]          rd_data_wb,
    output logic                      misaligned_wb,
    output logic [CNT_WIDTH-1:0]      retired_cnt
);
    logic                      valid_reg;
    logic [WIDTH-1:0]          pc_reg;
    logic                      rd_flag_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_address_reg;
    wb_src_t                   wb_src_reg;
    load_size_t                load_size_reg;
    logic                      load_signed_reg;
    logic [1:0]                addr_lo_reg;
    logic [WIDTH-1:0]          read_data_reg;
    logic [WIDTH-1:0]          alu_result_reg;
    logic [WIDTH-1:0]          hi_reg;
    logic [WIDTH-1:0]          lo_reg;
    logic [CNT_WIDTH-1:0]      cnt_reg;

    logic [WIDTH-1:0]          load_data;
    logic                      load_misaligned;
    logic [WIDTH-1:0]          result_next;

    // Flush beats stall: a bubble is inserted even while the stage is held.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_reg       <= 1'b0;
            pc_reg          <= '0;
            rd_flag_reg     <= 1'b0;
            rd_address_reg  <= '0;
            wb_src_reg      <= WB_NONE;
            load_size_reg   <= LS_BYTE;
            load_signed_reg <= 1'b0;
            addr_lo_reg     <= '0;
            read_data_reg   <= '0;
            alu_result_reg  <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            cnt_reg         <= '0;
        end else if (flush) begin
            valid_reg       <= 1'b0;
            pc_reg          <= '0;
            rd_flag_reg     <= 1'b0;
            rd_address_reg  <= '0;
            wb_src_reg      <= WB_NONE;
            load_size_reg   <= LS_BYTE;
            load_signed_reg <= 1'b0;
            addr_lo_reg     <= '0;
            read_data_reg   <= '0;
            alu_result_reg  <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
        end else if (!stall) begin
            valid_reg       <= valid_me;
            pc_reg          <= pc_me;
            rd_flag_reg     <= rd_me;
            rd_address_reg  <= rd_address_me;
            wb_src_reg      <= wb_src_me;
            load_size_reg   <= load_size_me;
            load_signed_reg <= load_signed_me;
            addr_lo_reg     <= addr_lo_me;
            read_data_reg   <= read_data_me;
            alu_result_reg  <= alu_result_me;
            hi_reg          <= hi_me;
            lo_reg          <= lo_me;
            if (valid_me) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    load_aligner #(.WIDTH(WIDTH)) u_load_aligner (
        .read_data   (read_data_reg),
        .addr_lo     (addr_lo_reg),
        .load_size   (load_size_reg),
        .load_signed (load_signed_reg),
        .data        (load_data),
        .misaligned  (load_misaligned)
    );

    always_comb begin
        result_next = '0;
        case (wb_src_reg)
            WB_ALU:  result_next = alu_result_reg;
            WB_LOAD: result_next = load_data;
            WB_LINK: result_next = pc_reg + WIDTH'(LINK_OFFSET);
            WB_HI:   result_next = hi_reg;
            WB_LO:   result_next = lo_reg;
            default: result_next = '0;
        endcase
    end

    assign valid_wb      = valid_reg;
    assign pc_wb         = pc_reg;
    assign rd_address_wb = rd_address_reg;
    assign rd_data_wb    = result_next;
    assign misaligned_wb = valid_reg & (wb_src_reg == WB_LOAD) & load_misaligned;
    // Register $zero is never written, and a faulting load never commits.
    assign rd_wb         = valid_reg & rd_flag_reg & (rd_address_reg != '0) & ~misaligned_wb;
    assign retired_cnt   = cnt_reg;
endmodule
